exec_controller: RTL and testbench

- Run/step/load sequencer for the single-cycle MIPS datapath.
- Owns the PC register, decides each cycle whether the datapath result commits, and captures EPC on exceptions.
- Adds switch-based PC loading, single-step execution, run/halt control and exception return (ERET).
- Sits between the board inputs (switches/keys) and the IMEM/REG/DMEM write enables.

---
 rtl/exec_ctrl_pkg.sv | 16 +
 rtl/btn_sync_edge.sv | 29 ++
 rtl/exec_controller.sv | 119 +++++++++++
 tb/tb_exec_controller.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/exec_ctrl_pkg.sv
// Shared definitions for the run/step/load sequencer of the single-cycle MIPS datapath.
// State encoding is visible on the state port, so the values are fixed.
package exec_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_EXC  = 2'd3
    } state_e;

    localparam int unsigned PC_W_DEF        = 8;
    localparam int unsigned CNT_W_DEF       = 16;
    localparam int unsigned SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/btn_sync_edge.sv
// Synchronizes an asynchronous board key and emits a registered 1-cycle pulse on its rising edge.
module btn_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic SYS_clk,
    input  logic SYS_rst,
    input  logic key_i,
    output logic pulse_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   pulse_q;

    always_ff @(posedge SYS_clk or negedge SYS_rst) begin
        if (!SYS_rst) begin
            sync_q  <= '0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], key_i};
            prev_q  <= sync_q[SYNC_STAGES-1];
            pulse_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/exec_controller.sv
// Run/step/load sequencer: owns PC, gates datapath commits, captures EPC and handles ERET.
module exec_controller
    import exec_ctrl_pkg::*;
#(
    parameter int unsigned PC_W        = PC_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic             SYS_clk,
    input  logic             SYS_rst,
    input  logic             SYS_run,
    input  logic             SYS_step,
    input  logic             SYS_load,
    input  logic             SYS_eret,
    input  logic [PC_W-1:0]  SYS_pc_val,
    input  logic [PC_W-1:0]  DP_pc_next,
    input  logic             DP_eh_flag,
    output logic [PC_W-1:0]  PC,
    output logic             commit,
    output logic [PC_W-1:0]  EPC,
    output logic             exc_pending,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    logic step_p, load_p, eret_p, run_s;
    logic [SYNC_STAGES-1:0] run_sync_q;

    btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_step (
        .SYS_clk(SYS_clk), .SYS_rst(SYS_rst), .key_i(SYS_step), .pulse_o(step_p)
    );
    btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_load (
        .SYS_clk(SYS_clk), .SYS_rst(SYS_rst), .key_i(SYS_load), .pulse_o(load_p)
    );
    btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_eret (
        .SYS_clk(SYS_clk), .SYS_rst(SYS_rst), .key_i(SYS_eret), .pulse_o(eret_p)
    );

    always_ff @(posedge SYS_clk or negedge SYS_rst) begin
        if (!SYS_rst) run_sync_q <= '0;
        else          run_sync_q <= {run_sync_q[SYNC_STAGES-2:0], SYS_run};
    end
    assign run_s = run_sync_q[SYNC_STAGES-1];

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d, epc_q, epc_d;
    logic              exc_q, exc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              commit_c;

    always_ff @(posedge SYS_clk or negedge SYS_rst) begin
        if (!SYS_rst) begin
            state_q <= ST_HALT;
            pc_q    <= RESET_PC;
            epc_q   <= '0;
            exc_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            exc_q   <= exc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        epc_d    = epc_q;
        exc_d    = exc_q;
        cnt_d    = cnt_q;
        commit_c = ((state_q == ST_RUN) || (state_q == ST_STEP)) && !DP_eh_flag;

        if (commit_c) begin
            pc_d  = DP_pc_next;
            cnt_d = cnt_q + 1'b1;
        end

        unique case (state_q)
            ST_HALT: begin
                if (load_p)      pc_d    = SYS_pc_val;
                else if (run_s)  state_d = ST_RUN;
                else if (step_p) state_d = ST_STEP;
            end
            ST_RUN, ST_STEP: begin
                // A faulting instruction never commits; its PC is kept for ERET.
                if (DP_eh_flag) begin
                    epc_d   = pc_q;
                    exc_d   = 1'b1;
                    state_d = ST_EXC;
                end else if (state_q == ST_STEP || !run_s || load_p) begin
                    state_d = ST_HALT;
                end
            end
            ST_EXC: begin
                if (load_p) begin
                    pc_d    = SYS_pc_val;
                    exc_d   = 1'b0;
                    state_d = ST_HALT;
                end else if (eret_p) begin
                    pc_d    = epc_q + 1'b1;
                    exc_d   = 1'b0;
                    state_d = ST_HALT;
                end
            end
            default: state_d = ST_HALT;
        endcase
    end

    assign PC          = pc_q;
    assign commit      = commit_c;
    assign EPC         = epc_q;
    assign exc_pending = exc_q;
    assign state       = state_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_exec_controller.sv
// Directed, table-driven bench for exec_controller with hand-computed expectations.
module tb_exec_controller;

    localparam logic [1:0] S_HALT = 2'd0, S_RUN = 2'd1, S_STEP = 2'd2, S_EXC = 2'd3;

    logic        SYS_clk = 1'b0, SYS_rst = 1'b1;
    logic        SYS_run = 1'b0, SYS_step = 1'b0, SYS_load = 1'b0, SYS_eret = 1'b0;
    logic [7:0]  SYS_pc_val = '0;
    logic [7:0]  DP_pc_next;
    logic        DP_eh_flag;
    logic [7:0]  PC, EPC;
    logic        commit, exc_pending;
    logic [1:0]  state;
    logic [15:0] instr_count;

    logic [7:0]  dp_fix = '0;
    logic        follow = 1'b0, eh_fix = 1'b0, eh_at42 = 1'b0;

    assign DP_pc_next = follow ? PC + 8'd1 : dp_fix;
    assign DP_eh_flag = eh_fix | (eh_at42 && PC == 8'h42);

    exec_controller #(.PC_W(8), .RESET_PC(8'h00), .CNT_W(16), .SYNC_STAGES(2)) dut (
        .SYS_clk(SYS_clk), .SYS_rst(SYS_rst), .SYS_run(SYS_run), .SYS_step(SYS_step),
        .SYS_load(SYS_load), .SYS_eret(SYS_eret), .SYS_pc_val(SYS_pc_val),
        .DP_pc_next(DP_pc_next), .DP_eh_flag(DP_eh_flag), .PC(PC), .commit(commit),
        .EPC(EPC), .exc_pending(exc_pending), .state(state), .instr_count(instr_count)
    );

    always #5 SYS_clk = ~SYS_clk;

    int unsigned errors = 0, checks = 0, ncommit = 0;
    logic [15:0] cnt_exp = '0;

    always @(negedge SYS_clk) if (commit) ncommit++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(negedge SYS_clk);
    endtask

    // k: 0=load 1=step 2=eret 3=load+eret
    task automatic press(input int unsigned k, input int unsigned hold);
        @(negedge SYS_clk);
        SYS_load = (k == 0 || k == 3);
        SYS_step = (k == 1);
        SYS_eret = (k == 2 || k == 3);
        tick(hold);
        SYS_load = 1'b0; SYS_step = 1'b0; SYS_eret = 1'b0;
        tick(6);
    endtask

    typedef struct {
        logic [7:0] load_val;
        logic [7:0] dp_next;
        logic       eh;
        logic [7:0] exp_pc;
        logic [1:0] exp_state;
        logic       exp_exc;
    } vec_t;

    vec_t vecs [4];

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned nc0;
        logic seen42, c42;
        vecs[0] = '{8'h10, 8'h20, 1'b0, 8'h20, S_HALT, 1'b0};
        vecs[1] = '{8'hFE, 8'hFF, 1'b0, 8'hFF, S_HALT, 1'b0};
        vecs[2] = '{8'hA5, 8'h00, 1'b1, 8'hA5, S_EXC,  1'b1};
        vecs[3] = '{8'h00, 8'h80, 1'b0, 8'h80, S_HALT, 1'b0};

        // 1: reset, then idle with DP_pc_next = 0x05
        dp_fix = 8'h05;
        #1 SYS_rst = 1'b0;
        tick(3);
        chk("rst_pc", PC, 8'h00);
        chk("rst_epc", EPC, 8'h00);
        chk("rst_exc", exc_pending, 1'b0);
        SYS_rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("idle_pc", PC, 8'h00);
            chk("idle_state", state, S_HALT);
            chk("idle_commit", commit, 1'b0);
            chk("idle_cnt", instr_count, 16'd0);
        end

        // 2: load 0x3C, then keep holding the key with a new value
        @(negedge SYS_clk);
        SYS_pc_val = 8'h3C; SYS_load = 1'b1;
        tick(4);
        chk("load_pc", PC, 8'h3C);
        chk("load_state", state, S_HALT);
        SYS_pc_val = 8'h55;
        tick(10);
        chk("load_hold_pc", PC, 8'h3C);
        chk("load_cnt", instr_count, 16'd0);
        SYS_load = 1'b0;
        tick(4);

        // 3: step held 20 cycles
        dp_fix = 8'h3D;
        nc0 = ncommit;
        press(1, 20);
        cnt_exp = cnt_exp + 1;
        chk("step_commits", ncommit - nc0, 1);
        chk("step_pc", PC, 8'h3D);
        chk("step_cnt", instr_count, cnt_exp);
        chk("step_state", state, S_HALT);

        // 4: free-run with PC+1, exception at 0x42
        follow = 1'b1; eh_at42 = 1'b1;
        nc0 = ncommit; seen42 = 1'b0; c42 = 1'b0;
        SYS_run = 1'b1;
        for (int i = 0; i < 60 && state != S_EXC; i++) begin
            tick(1);
            if (state == S_RUN && PC == 8'h42) begin
                seen42 = 1'b1;
                if (commit) c42 = 1'b1;
            end
        end
        cnt_exp = cnt_exp + 5;
        chk("run_seen42", seen42, 1'b1);
        chk("run_commit42", c42, 1'b0);
        chk("run_commits", ncommit - nc0, 5);
        chk("exc_state", state, S_EXC);
        chk("exc_epc", EPC, 8'h42);
        chk("exc_pending", exc_pending, 1'b1);
        chk("exc_cnt", instr_count, cnt_exp);
        press(1, 2);
        chk("exc_hold_pc", PC, 8'h42);
        chk("exc_hold_state", state, S_EXC);

        // 5a: ERET with run off
        SYS_run = 1'b0; follow = 1'b0; eh_at42 = 1'b0;
        tick(4);
        press(2, 3);
        chk("eret_pc", PC, 8'h43);
        chk("eret_exc", exc_pending, 1'b0);
        chk("eret_state", state, S_HALT);
        chk("eret_epc_kept", EPC, 8'h42);

        // 5b: exception at 0xFF, ERET wraps to 0x00
        SYS_pc_val = 8'hFF;
        press(0, 2);
        eh_fix = 1'b1;
        press(1, 2);
        chk("wrap_epc", EPC, 8'hFF);
        chk("wrap_state_exc", state, S_EXC);
        eh_fix = 1'b0;
        press(2, 2);
        chk("wrap_pc", PC, 8'h00);
        chk("wrap_state", state, S_HALT);

        // 5c: load and ERET together, load wins
        eh_fix = 1'b1;
        press(1, 2);
        eh_fix = 1'b0;
        chk("both_pre_state", state, S_EXC);
        SYS_pc_val = 8'h77;
        press(3, 2);
        chk("both_pc", PC, 8'h77);
        chk("both_exc", exc_pending, 1'b0);
        chk("both_state", state, S_HALT);
        chk("both_epc", EPC, 8'h00);
        chk("both_cnt", instr_count, cnt_exp);

        // table: load a PC, single-step once
        for (int v = 0; v < 4; v++) begin
            SYS_pc_val = vecs[v].load_val;
            press(0, 2);
            chk("tbl_load_pc", PC, vecs[v].load_val);
            dp_fix = vecs[v].dp_next;
            eh_fix = vecs[v].eh;
            nc0 = ncommit;
            press(1, 3);
            eh_fix = 1'b0;
            if (!vecs[v].eh) cnt_exp = cnt_exp + 1;
            chk("tbl_pc", PC, vecs[v].exp_pc);
            chk("tbl_state", state, vecs[v].exp_state);
            chk("tbl_exc", exc_pending, vecs[v].exp_exc);
            chk("tbl_commits", ncommit - nc0, vecs[v].eh ? 0 : 1);
            chk("tbl_cnt", instr_count, cnt_exp);
            if (vecs[v].exp_exc) begin
                chk("tbl_epc", EPC, vecs[v].load_val);
                press(0, 2);
                chk("tbl_clr_state", state, S_HALT);
            end
        end

        // 6: asynchronous reset mid-RUN
        follow = 1'b1;
        SYS_run = 1'b1;
        for (int i = 0; i < 20 && state != S_RUN; i++) tick(1);
        tick(3);
        chk("pre_rst_state", state, S_RUN);
        #2 SYS_rst = 1'b0;
        #1;
        chk("arst_pc", PC, 8'h00);
        chk("arst_state", state, S_HALT);
        chk("arst_epc", EPC, 8'h00);
        chk("arst_exc", exc_pending, 1'b0);
        chk("arst_cnt", instr_count, 16'd0);
        chk("arst_commit", commit, 1'b0);
        SYS_run = 1'b0; follow = 1'b0;
        tick(2);
        SYS_rst = 1'b1;
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
